nco_phase_sequencer: RTL and testbench

Phase-accumulator sequencer directly upstream of the CORDIC sine stage. It advances a fixed-point phase by a programmable step on each sample tick, wrapped modulo 2π. It drives the sine stage's `in_angle`/`update` pair and holds the angle stable for the whole computation. It captures the sine result when the stage reports `ready` and presents it downstream through a valid/ack output register.

---
 rtl/nco_phase_sequencer_if.sv | 30 +++
 rtl/nco_phase_sequencer.sv | 175 +++++++++++++++++
 tb/tb_nco_phase_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nco_phase_sequencer_if.sv
// Bundle of the step/tick control, sine-stage handshake and sample output
// signals shared between the phase sequencer and its environment.
interface nco_phase_sequencer_if;
  logic        step_load;
  logic [17:0] step_in;
  logic        tick;
  logic        sine_ready;
  logic [15:0] sine_data;
  logic [17:0] angle;
  logic        update;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ack;
  logic        busy;
  logic        overrun;
  logic        dropped;
  logic        timeout;

  // Sequencer side.
  modport master (
    input  step_load, step_in, tick, sine_ready, sine_data, sample_ack,
    output angle, update, sample, sample_valid, busy, overrun, dropped, timeout
  );

  // Environment side: control source, sine stage and downstream consumer.
  modport slave (
    output step_load, step_in, tick, sine_ready, sine_data, sample_ack,
    input  angle, update, sample, sample_valid, busy, overrun, dropped, timeout
  );
endinterface

// File: rtl/nco_phase_sequencer.sv
// Phase accumulator feeding the CORDIC sine stage: advances the phase modulo
// 2*pi on each tick, issues the angle, and buffers the returned sine sample.
module nco_phase_sequencer #(
  parameter int PI2     = 51472,
  parameter int TIMEOUT = 63
) (
  input logic                   clk,
  input logic                   reset,
  nco_phase_sequencer_if.master io_bus
);

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [18:0] MOD      = 19'(4 * PI2);
  localparam logic [17:0] STEP_LIM = 18'(2 * PI2);
  localparam logic [17:0] STEP_MAX = 18'(2 * PI2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [17:0]     r_phase;
  logic [17:0]     r_step;
  logic [17:0]     r_angle;
  logic [CW-1:0]   r_cnt;
  logic            r_update;
  logic [15:0]     r_sample;
  logic            r_sample_valid;
  logic            r_busy;
  logic            r_overrun;
  logic            r_dropped;
  logic            r_timeout;

  logic [18:0]     w_sum;
  logic [18:0]     w_wrapped;
  logic [17:0]     w_phase_next;
  logic [17:0]     w_step_sat;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_accept;
  logic            w_capture;
  logic            w_expire;
  logic            w_overrun_evt;

  // Both operands stay below 4*PI2 and 2*PI2, so one conditional subtract wraps.
  assign w_sum        = {1'b0, r_phase} + {1'b0, r_step};
  assign w_wrapped    = (w_sum >= MOD) ? (w_sum - MOD) : w_sum;
  assign w_phase_next = w_wrapped[17:0];
  assign w_step_sat   = (io_bus.step_in >= STEP_LIM) ? STEP_MAX : io_bus.step_in;
  assign w_cnt_inc    = r_cnt + CW'(1);

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_expire      = 1'b0;
    w_overrun_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.tick) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_overrun_evt = io_bus.tick;
        w_state_next  = S_ARM;
      end
      // Dead cycle: a ready left over from the previous computation may
      // still be visible here, so it is not trusted until WAIT.
      S_ARM: begin
        w_overrun_evt = io_bus.tick;
        w_state_next  = S_WAIT;
      end
      S_WAIT: begin
        w_overrun_evt = io_bus.tick;
        if (io_bus.sine_ready) begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_expire     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // The tick in the same cycle as a step load still sees the old r_step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step <= '0;
    end else if (io_bus.step_load) begin
      r_step <= w_step_sat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase  <= '0;
      r_angle  <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_accept;
      if (w_accept) begin
        r_phase <= w_phase_next;
        r_angle <= w_phase_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_ARM) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT && !io_bus.sine_ready) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // A capture outranks a simultaneous ack: the fresh sample stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_dropped      <= 1'b0;
    end else if (w_capture) begin
      r_sample       <= io_bus.sine_data;
      r_sample_valid <= 1'b1;
      if (r_sample_valid && !io_bus.sample_ack) begin
        r_dropped <= 1'b1;
      end
    end else if (r_sample_valid && io_bus.sample_ack) begin
      r_sample_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign io_bus.angle        = r_angle;
  assign io_bus.update       = r_update;
  assign io_bus.sample       = r_sample;
  assign io_bus.sample_valid = r_sample_valid;
  assign io_bus.busy         = r_busy;
  assign io_bus.overrun      = r_overrun;
  assign io_bus.dropped      = r_dropped;
  assign io_bus.timeout      = r_timeout;

endmodule

// File: tb/tb_nco_phase_sequencer.sv
// Directed bench for nco_phase_sequencer: wrap, saturation, handshake,
// overrun/drop, timeout, stale ready and asynchronous reset.
module tb_nco_phase_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  nco_phase_sequencer_if bus ();

  nco_phase_sequencer #(
    .PI2     (51472),
    .TIMEOUT (63)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_angle"},   bus.angle, 0);
    check({tag, "_update"},  bus.update, 0);
    check({tag, "_sample"},  bus.sample, 0);
    check({tag, "_valid"},   bus.sample_valid, 0);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    check({tag, "_dropped"}, bus.dropped, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
  endtask

  task automatic load_step(input logic [17:0] v);
    bus.step_load = 1'b1;
    bus.step_in   = v;
    cyc();
    bus.step_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic ack();
    bus.sample_ack = 1'b1;
    cyc();
    bus.sample_ack = 1'b0;
    check("ack_clears_valid", bus.sample_valid, 0);
  endtask

  // One complete tick -> capture; the sine result arrives after wait_n WAIT cycles.
  task automatic txn(input logic [17:0] exp_angle, input logic [15:0] data,
                     input int wait_n, input logic stale);
    bus.tick       = 1'b1;
    bus.sine_ready = stale;
    bus.sine_data  = data;
    cyc();
    bus.tick = 1'b0;
    check("angle", bus.angle, exp_angle);
    check("update_pulse", bus.update, 1);
    check("busy_issue", bus.busy, 1);
    cyc();
    check("update_clear", bus.update, 0);
    cyc();
    if (stale) check("stale_ready_ignored", bus.sample_valid, 0);
    if (wait_n > 0) begin
      bus.sine_ready = 1'b0;
      repeat (wait_n) cyc();
      check("busy_wait", bus.busy, 1);
    end
    bus.sine_ready = 1'b1;
    cyc();
    bus.sine_ready = 1'b0;
    check("sample", bus.sample, data);
    check("sample_valid", bus.sample_valid, 1);
    check("busy_done", bus.busy, 0);
    $display("txn angle=%0d sample=0x%04h valid=%0b dropped=%0b",
             bus.angle, bus.sample, bus.sample_valid, bus.dropped);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    bus.step_load  = 1'b0;
    bus.step_in    = '0;
    bus.tick       = 1'b0;
    bus.sine_ready = 1'b0;
    bus.sine_data  = '0;
    bus.sample_ack = 1'b0;
    repeat (2) cyc();
    check_all_zero("reset");
    reset = 1'b0;
    cyc();
    check("idle_busy", bus.busy, 0);

    // Wrap: step 0x4000, thirteenth tick wraps 212992 -> 7104.
    load_step(18'h04000);
    for (int k = 1; k <= 13; k++) begin
      txn(18'((16384 * k) % 205888), 16'(k), 3, 1'b0);
      ack();
    end
    check("wrap_final", bus.angle, 7104);

    // Saturation; a tick coinciding with a step load uses the old step.
    do_reset();
    load_step(18'h20000);
    txn(18'd102943, 16'h0101, 1, 1'b0);
    ack();
    txn(18'd205886, 16'h0202, 1, 1'b0);
    ack();
    bus.step_load = 1'b1;
    bus.step_in   = 18'h04000;
    txn(18'd102941, 16'h0303, 1, 1'b0);
    bus.step_load = 1'b0;
    ack();
    txn(18'd119325, 16'h0404, 1, 1'b0);
    ack();

    // Handshake with 0x5A82.
    do_reset();
    load_step(18'h04000);
    txn(18'd16384, 16'h5A82, 16, 1'b0);
    repeat (3) cyc();
    check("valid_held", bus.sample_valid, 1);
    check("sample_held", bus.sample, 16'h5A82);
    ack();
    check("sample_after_ack", bus.sample, 16'h5A82);

    // Overrun: second tick 5 cycles after the first, while in WAIT.
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    check("ovr_angle", bus.angle, 32768);
    repeat (4) cyc();
    check("ovr_not_yet", bus.overrun, 0);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    check("overrun_set", bus.overrun, 1);
    check("ovr_angle_held", bus.angle, 32768);
    check("ovr_no_update", bus.update, 0);
    bus.sine_ready = 1'b1;
    bus.sine_data  = 16'h1111;
    cyc();
    bus.sine_ready = 1'b0;
    check("first_sample", bus.sample, 16'h1111);
    check("no_drop_yet", bus.dropped, 0);
    // Phase advanced once only: next angle is 49152. No ack -> drop.
    txn(18'd49152, 16'h2222, 2, 1'b0);
    check("dropped_set", bus.dropped, 1);

    // Timeout: 63 WAIT cycles without ready, sample left untouched.
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    check("to_angle", bus.angle, 65536);
    cyc();
    cyc();
    repeat (62) cyc();
    check("timeout_not_yet", bus.timeout, 0);
    check("timeout_busy", bus.busy, 1);
    cyc();
    check("timeout_set", bus.timeout, 1);
    check("timeout_idle", bus.busy, 0);
    check("timeout_valid_kept", bus.sample_valid, 1);
    check("timeout_sample_kept", bus.sample, 16'h2222);
    txn(18'd81920, 16'h3333, 0, 1'b0);
    check("sticky_timeout", bus.timeout, 1);
    check("sticky_overrun", bus.overrun, 1);
    ack();

    // Stale ready held through ISSUE/ARM.
    txn(18'd98304, 16'h4444, 0, 1'b1);
    ack();

    // Asynchronous reset in WAIT.
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    check("pre_reset_angle", bus.angle, 114688);
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_wait");
    bus.sine_ready = 1'b1;
    bus.sine_data  = 16'h7777;
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    bus.sine_ready = 1'b0;
    check("post_reset_no_sample", bus.sample_valid, 0);
    check("post_reset_idle", bus.busy, 0);

    // Asynchronous reset during the update pulse.
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    check("issue_update", bus.update, 1);
    #2 reset = 1'b1;
    #1;
    check("async_issue_update", bus.update, 0);
    check("async_issue_busy", bus.busy, 0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
